// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with stall, branch, deferred branch and flush
//
// Purpose: generates the registered fetch address (pc) and instruction-memory
// enable (ce). Redirect priority while ce=1: flush > stall > branch > pending
// branch > sequential increment. A branch seen during a stall is held until
// the stall releases; the last one seen during the stall wins.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : redirect targets have their low ALIGN_BITS bits cleared, and
//               misalign_err pulses for one cycle if any cleared bit was set.
//   undefined : targets load unmodified, misalign_err is tied 0.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   stall         in   hold pc
//   branch_flag   in   branch redirect request
//   branch_target in   branch redirect address [PC_WIDTH]
//   flush         in   exception/trap redirect request
//   flush_target  in   exception/trap address [PC_WIDTH]
//   pc            out  fetch address [PC_WIDTH], registered
//   ce            out  instruction-memory enable, registered
//   misalign_err  out  misaligned redirect target seen
module pc_unit #(
  parameter int                   PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                   PC_INC       = 4,
  parameter int                   ALIGN_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_flag,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] flush_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ce,
  output logic                misalign_err
);

  if (ALIGN_BITS < 0 || ALIGN_BITS >= PC_WIDTH) begin : g_bad_align
    $error("pc_unit: ALIGN_BITS must be in [0, PC_WIDTH-1]");
  end

  logic                ce_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_valid_q, pend_valid_d;
  logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                load;
  logic [PC_WIDTH-1:0] tgt;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
    PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    load          = 1'b0;
    tgt           = '0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d    = 1'b0;
`endif
    // Until the first enabled cycle every request is ignored and pc stays
    // at the reset vector.
    if (ce_q) begin
      if (flush) begin
        load         = 1'b1;
        tgt          = flush_target;
        pend_valid_d = 1'b0;
      end else if (stall) begin
        if (branch_flag) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target;
        end
      end else if (branch_flag) begin
        load         = 1'b1;
        tgt          = branch_target;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        load         = 1'b1;
        tgt          = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        // Wraps silently modulo 2^PC_WIDTH.
        pc_d = pc_q + PC_WIDTH'(PC_INC);
      end
    end
    if (load) begin
`ifdef PC_ALIGN_CHECK_EN
      pc_d       = tgt & ~ALIGN_MASK;
      misalign_d = |(tgt & ALIGN_MASK);
`else
      pc_d = tgt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q          <= 1'b0;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      ce_q          <= 1'b1;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign pc = pc_q;
  assign ce = ce_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit (directed table, corner sequences, random vs model)
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance: reset vector 0, increment 4
  logic        rst, stall, br, fl;
  logic [31:0] bt, ft;
  logic [31:0] pc;
  logic        ce, mis;

  // 8-bit instance: reset vector 0x20, increment 4
  localparam logic [7:0] RV8 = 8'h20;
  logic       rst8, stall8, br8, fl8;
  logic [7:0] bt8, ft8;
  logic [7:0] pc8;
  logic       ce8, mis8;

  pc_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .PC_INC(4), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(br), .branch_target(bt),
    .flush(fl), .flush_target(ft), .pc(pc), .ce(ce), .misalign_err(mis));

  pc_unit #(.PC_WIDTH(8), .RESET_VECTOR(RV8), .PC_INC(4), .ALIGN_BITS(2)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .branch_flag(br8), .branch_target(bt8),
    .flush(fl8), .flush_target(ft8), .pc(pc8), .ce(ce8), .misalign_err(mis8));

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] ft;
    logic [31:0] epc;
    logic        ece, emis;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic r, logic s, logic b, logic [31:0] bta, logic f,
                              logic [31:0] fta, logic [31:0] epc, logic ece, logic emis);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.bt = bta; v.fl = f; v.ft = fta;
    v.epc = epc; v.ece = ece; v.emis = emis;
    vt.push_back(v);
  endfunction

  // Reference model for the 32-bit instance, written from the priority rules.
  logic [31:0] m_pc;
  logic        m_ce, m_mis;
  logic [31:0] m_pend[$];

  function automatic void m_redirect(logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    m_pc  = t - (t % 32'd4);
    m_mis = (t % 32'd4) != 0;
`else
    m_pc  = t;
`endif
  endfunction

  function automatic void m_step(logic r, logic s, logic b, logic [31:0] bta,
                                 logic f, logic [31:0] fta);
    m_mis = 1'b0;
    if (r) begin
      m_ce = 1'b0; m_pc = 32'h0; m_pend.delete();
    end else if (!m_ce) begin
      m_ce = 1'b1;
    end else if (f) begin
      m_redirect(fta); m_pend.delete();
    end else if (s) begin
      if (b) begin m_pend.delete(); m_pend.push_back(bta); end
    end else if (b) begin
      m_redirect(bta); m_pend.delete();
    end else if (m_pend.size() != 0) begin
      m_redirect(m_pend.pop_front());
    end else begin
      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(logic r, logic s, logic b, logic [7:0] bta, logic f, logic [7:0] fta);
    rst8 = r; stall8 = s; br8 = b; bt8 = bta; fl8 = f; ft8 = fta;
  endtask

  logic [31:0] al_pc0, al_pc1;
  logic        al_m0;

  initial begin
    rst = 1'b1; stall = 0; br = 0; bt = 0; fl = 0; ft = 0;
    drive8(1, 0, 0, 8'h0, 0, 8'h0);

`ifdef PC_ALIGN_CHECK_EN
    al_pc0 = 32'h100; al_pc1 = 32'h104; al_m0 = 1'b1;
`else
    al_pc0 = 32'h103; al_pc1 = 32'h107; al_m0 = 1'b0;
`endif

    //    rst st br bt          fl ft        exp_pc      ce mis
    add(1, 0, 0, 32'h0,      0, 32'h0,    32'h0,      0, 0);
    add(1, 1, 1, 32'h500,    1, 32'h600,  32'h0,      0, 0);
    add(1, 0, 0, 32'h0,      0, 32'h0,    32'h0,      0, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h0,      1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h4,      1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h8,      1, 0);
    add(0, 0, 1, 32'h100,    0, 32'h0,    32'h100,    1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h104,    1, 0);
    add(0, 1, 1, 32'h200,    0, 32'h0,    32'h104,    1, 0);
    add(0, 1, 1, 32'h300,    0, 32'h0,    32'h104,    1, 0);
    add(0, 1, 0, 32'h0,      0, 32'h0,    32'h104,    1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h300,    1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h304,    1, 0);
    add(0, 1, 1, 32'h400,    1, 32'h80,   32'h80,     1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h84,     1, 0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    32'h88,     1, 0);
    add(0, 0, 1, 32'h103,    0, 32'h0,    al_pc0,     1, al_m0);
    add(0, 0, 0, 32'h0,      0, 32'h0,    al_pc1,     1, 0);

    #1;
    foreach (vt[i]) begin
      rst = vt[i].rst; stall = vt[i].stall; br = vt[i].br; bt = vt[i].bt;
      fl = vt[i].fl; ft = vt[i].ft;
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vt[i].epc);
      chk($sformatf("vec%0d_ce", i), {31'b0, ce}, {31'b0, vt[i].ece});
      chk($sformatf("vec%0d_mis", i), {31'b0, mis}, {31'b0, vt[i].emis});
    end

    // 8-bit: requests on the first edge after reset release are ignored.
    drive8(1, 0, 0, 8'h0, 0, 8'h0); tick();
    chk("w8_rst_pc", {24'b0, pc8}, {24'b0, RV8});
    chk("w8_rst_ce", {31'b0, ce8}, 32'd0);
    drive8(0, 1, 1, 8'h44, 1, 8'h99); tick();
    chk("w8_first_pc", {24'b0, pc8}, {24'b0, RV8});
    chk("w8_first_ce", {31'b0, ce8}, 32'd1);
    drive8(0, 0, 0, 8'h0, 0, 8'h0); tick();
    chk("w8_inc_pc", {24'b0, pc8}, 32'h24);
    // Wrap from 0xFC to 0x00, no flag.
    drive8(0, 0, 1, 8'hFC, 0, 8'h0); tick();
    chk("w8_br_fc", {24'b0, pc8}, 32'hFC);
    drive8(0, 0, 0, 8'h0, 0, 8'h0); tick();
    chk("w8_wrap_pc", {24'b0, pc8}, 32'h00);
    chk("w8_wrap_mis", {31'b0, mis8}, 32'd0);
    // Branch deferred by stall, then reset discards it.
    drive8(0, 1, 1, 8'h50, 0, 8'h0); tick();
    chk("w8_stall_pc", {24'b0, pc8}, 32'h00);
    drive8(1, 0, 0, 8'h0, 0, 8'h0); tick();
    chk("w8_midrst_pc", {24'b0, pc8}, {24'b0, RV8});
    chk("w8_midrst_ce", {31'b0, ce8}, 32'd0);
    drive8(0, 0, 0, 8'h0, 0, 8'h0); tick();
    chk("w8_rel_pc", {24'b0, pc8}, {24'b0, RV8});
    tick();
    chk("w8_nopend1", {24'b0, pc8}, 32'h24);
    tick();
    chk("w8_nopend2", {24'b0, pc8}, 32'h28);

    // Randomized run on the 32-bit instance against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = (i < 2) ? 1'b1 : ($urandom_range(63) == 0);
      stall = ($urandom_range(2) == 0);
      br    = ($urandom_range(3) == 0);
      bt    = $urandom;
      fl    = ($urandom_range(15) == 0);
      ft    = $urandom;
      m_step(rst, stall, br, bt, fl, ft);
      tick();
      chk($sformatf("rnd%0d_pc", i), pc, m_pc);
      chk($sformatf("rnd%0d_ce", i), {31'b0, ce}, {31'b0, m_ce});
      chk($sformatf("rnd%0d_mis", i), {31'b0, mis}, {31'b0, m_mis});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter block for the fetch stage; successor to the fixed 6-bit, increment-only PC. Generates the fetch address and instruction-memory enable. Supports a configurable width, reset vector and increment, pipeline stall, branch redirect, and pipeline flush to an exception/trap target. Branches that arrive during a stall are held until the stall releases.

Parameters:
PC_WIDTH, 32, width of pc and of all target inputs
RESET_VECTOR, 0, pc value while ce=0 and after reset
PC_INC, 4, amount added to pc per sequential fetch
ALIGN_BITS, 2, number of pc LSBs that must be zero (used only by the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  hold pc (downstream not ready)
branch_flag  in  1  redirect request from execute, valid for one cycle
branch_target  in  PC_WIDTH  redirect address qualified by branch_flag
flush  in  1  exception/trap redirect; highest priority after rst
flush_target  in  PC_WIDTH  address qualified by flush
pc  out  PC_WIDTH  fetch address (registered)
ce  out  1  instruction-memory enable (registered)
misalign_err  out  1  target misaligned (optional feature; constant 0 when disabled)

Behaviour:
- Reset (rst=1 at an edge): ce<=0, pc<=RESET_VECTOR, pend_valid<=0, misalign_err<=0. Reset mid-operation discards any pending branch.
- ce: registered copy of !rst. It goes 1 on the first edge with rst=0, so the first fetch of RESET_VECTOR occurs one cycle after reset deasserts.
- While ce=0, pc holds RESET_VECTOR, and branch_flag, flush and stall are ignored.
- While ce=1, pc updates at each edge using this priority:
  1. flush=1: pc<=flush_target; pend_valid<=0. Flush overrides stall and any pending or incoming branch.
  2. stall=1: pc holds. If branch_flag=1, capture pend_target<=branch_target and pend_valid<=1. A later branch_flag during the same stall overwrites the pending target (last wins).
  3. branch_flag=1: pc<=branch_target; pend_valid<=0. An incoming branch beats a pending one.
  4. pend_valid=1: pc<=pend_target; pend_valid<=0.
  5. Otherwise: pc<=pc+PC_INC, modulo 2^PC_WIDTH. Wrap-around from all-ones to small values is silent; no flag.
- Latency: a redirect is visible on pc the cycle after the request edge, or the cycle after stall deasserts if the branch was deferred.
- Internal state: pend_valid (1 bit) and pend_target (PC_WIDTH); not exported.
- No combinational path from any input to pc or ce.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - When a redirect is accepted (flush, branch, or pending apply), the target's low ALIGN_BITS bits are forced to 0 before loading.
  - misalign_err<=1 for exactly one cycle if any of those dropped bits was 1.
  - A misaligned branch captured during a stall raises the flag when it is applied, not when it is captured.
  - Sequential increments never raise the flag.
- Not defined: targets load unmodified, misalign_err is tied 0, and no masking logic is synthesised.

Test Plan:
- Reset release: PC_WIDTH=32 and RESET_VECTOR=0; hold rst 3 cycles then deassert. Required: ce=0 and pc=0 during reset; ce=1 one edge later; then pc=0x0,0x4,0x8 on successive cycles.
- Branch: branch_flag=1 with branch_target=0x100 when pc=0x8. Required: next pc=0x100, then 0x104.
- Deferred branch: stall=1 for 3 cycles, with branch_flag pulsed in cycle 1 to 0x200 and in cycle 2 to 0x300. Required: pc frozen during the stall; first pc after release=0x300.
- Flush priority: flush=1 to 0x80, with stall=1 and branch_flag=1 to 0x400 in the same cycle. Required: next pc=0x80, the pending branch is cleared, and pc continues 0x84.
- Wrap and reset mid-operation: PC_WIDTH=8 with pc=0xFC. Required: next pc=0x00. Then assert rst while a branch is pending; required: pc=RESET_VECTOR, and the pending branch is never applied.
- PC_ALIGN_CHECK_EN defined: branch_target=0x103. Required: pc=0x100, with misalign_err=1 for one cycle and then 0. Without the macro: pc=0x103 and misalign_err=0.
